// File: rtl/mb_intra_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mb_intra_sequencer_pkg
// Purpose  : Shared constants and the one-hot controller state encoding for
//            the intra macroblock sequencer.
// Revision : 1.0  initial release
// ============================================================================
package mb_intra_sequencer_pkg;

  // Default width of macroblock coordinates and grid dimensions.
  localparam int COORD_W = 10;

  // Luma macroblock edge length in pixels.
  localparam int MB_SIZE = 16;

  // One-hot encoding, same style as the mode-decision engine's controller.
  typedef enum logic [6:0] {
    ST_IDLE   = 7'b000_0001,
    ST_CLEAR  = 7'b000_0010,
    ST_FETCH  = 7'b000_0100,
    ST_LAUNCH = 7'b000_1000,
    ST_RUN    = 7'b001_0000,
    ST_EMIT   = 7'b010_0000,
    ST_DONE   = 7'b100_0000
  } seq_state_t;

endpackage : mb_intra_sequencer_pkg
`default_nettype wire

// File: rtl/mb_raster_counter.sv
`default_nettype none
// ============================================================================
// Module   : mb_raster_counter
// Purpose  : Raster-order macroblock coordinate walker. Captures the grid
//            size on load (a zero dimension counts as one) and steps x then y
//            on advance. Shared by the luma and chroma sequencers.
// Revision : 1.0  initial release
// ============================================================================
module mb_raster_counter #(
  parameter int COORD_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               advance,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  logic [COORD_W-1:0] w_lim;
  logic [COORD_W-1:0] h_lim;
  logic               x_at_end;

  assign x_at_end = (x == (w_lim - ONE));
  // Decoded from registers only, so it is safe to drive outputs from it.
  assign last     = x_at_end && (y == (h_lim - ONE));

  // Grid size capture and raster stepping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_lim <= ONE;
      h_lim <= ONE;
      x     <= '0;
      y     <= '0;
    end else if (load) begin
      w_lim <= (w == '0) ? ONE : w;
      h_lim <= (h == '0) ? ONE : h;
      x     <= '0;
      y     <= '0;
    end else if (advance) begin
      if (x_at_end) begin
        x <= '0;
        y <= y + ONE;
      end else begin
        x <= x + ONE;
      end
    end
  end

endmodule : mb_raster_counter
`default_nettype wire

// File: rtl/mb_intra_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mb_intra_sequencer
// Purpose  : Frame-level controller that walks the macroblock grid in raster
//            order, launches the 16x16 intra mode-decision engine once per
//            macroblock and hands each result to the bitstream writer.
// Revision : 1.0  initial release
// ============================================================================
module mb_intra_sequencer #(
  parameter int COORD_W = mb_intra_sequencer_pkg::COORD_W,
  parameter int CYC_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               abort,
  input  logic [COORD_W-1:0] mb_w,
  input  logic [COORD_W-1:0] mb_h,
  input  logic               src_valid,
  output logic               src_ready,
  output logic               pick_start,
  output logic               pick_clear,
  output logic [COORD_W-1:0] pick_x,
  output logic [COORD_W-1:0] pick_y,
  input  logic               pick_done,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_last,
  output logic [CYC_W-1:0]   mb_cycles,
  output logic               busy,
  output logic               frame_done
);

  import mb_intra_sequencer_pkg::*;

  localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

  seq_state_t       state;
  seq_state_t       state_next;
  logic             mb_last;
  logic             rc_load;
  logic             rc_advance;
  logic [CYC_W-1:0] cyc_cnt;
  logic [CYC_W-1:0] cyc_inc;

  // The engine results are only held until its next start, so coordinates
  // advance only on the writer handshake, never earlier.
  assign rc_load    = (state == ST_IDLE) && frame_start && !abort;
  assign rc_advance = (state == ST_EMIT) && res_ready && !mb_last && !abort;

  mb_raster_counter #(
    .COORD_W (COORD_W)
  ) u_raster (
    .clk     (clk),
    .rst     (rst),
    .load    (rc_load),
    .advance (rc_advance),
    .w       (mb_w),
    .h       (mb_h),
    .x       (pick_x),
    .y       (pick_y),
    .last    (mb_last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded outputs (no input-to-output paths).
  always_comb begin
    state_next = state;
    src_ready  = 1'b0;
    pick_start = 1'b0;
    pick_clear = 1'b0;
    res_valid  = 1'b0;
    res_last   = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (frame_start) state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        pick_clear = 1'b1;
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        src_ready = 1'b1;
        if (src_valid) state_next = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        pick_start = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (pick_done) state_next = ST_EMIT;
      end
      ST_EMIT: begin
        res_valid = 1'b1;
        res_last  = mb_last;
        if (res_ready) state_next = mb_last ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (abort) state_next = ST_IDLE;
  end

  assign cyc_inc = (&cyc_cnt) ? cyc_cnt : (cyc_cnt + CYC_ONE);

  // Per-macroblock launch-to-done cycle counter, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt   <= '0;
      mb_cycles <= '0;
    end else if (state == ST_LAUNCH) begin
      cyc_cnt <= '0;
    end else if (state == ST_RUN) begin
      cyc_cnt <= cyc_inc;
      // cyc_inc counts the done cycle itself, giving launch-to-done distance.
      if (pick_done && !abort) mb_cycles <= cyc_inc;
    end
  end

endmodule : mb_intra_sequencer
`default_nettype wire
